// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// State encoding, parameter defaults and a counter-width helper.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSend   = 2'd1,
    StWaitHi = 2'd2,
    StWaitLo = 2'd3
  } state_e;

  localparam int unsigned DefaultNumReq      = 4;
  localparam int unsigned DefaultMaxPktLen   = 64;
  localparam int unsigned DefaultBusyTimeout = 4;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr_i, wrapping.
// Produces a one-hot grant and its binary index.
module uart_tx_scheduler_rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      any_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = 0;
    // Scan farthest-first so the nearest requester after ptr_i writes last and wins.
    for (int unsigned i = NumReq; i >= 1; i--) begin
      cand = (32'(ptr_i) + i) % NumReq;
      if (req_i[cand]) begin
        gnt_o = NumReq'(1) << cand;
        idx_o = IdxW'(cand);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx serializer between NUM_REQ byte-stream requesters,
// round-robin at packet granularity, one byte outstanding at a time.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DefaultNumReq,
  parameter int unsigned MAX_PKT_LEN  = DefaultMaxPktLen,
  parameter int unsigned BUSY_TIMEOUT = DefaultBusyTimeout
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_active,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_act,
  input  logic                 i_tx_busy,
  output logic                 o_err_truncate,
  output logic                 o_err_timeout
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = cnt_width(MAX_PKT_LEN);
  localparam int unsigned TmoW = cnt_width(BUSY_TIMEOUT);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gidx_q, gidx_d;
  logic [CntW-1:0] count_q, count_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            last_q, last_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_act_q, tx_act_d;
  logic            err_trunc_q, err_trunc_d;
  logic            err_tmo_q, err_tmo_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] grant_oh;

  uart_tx_scheduler_rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_arb (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(NUM_REQ - 1);
      gidx_q      <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      last_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_act_q    <= 1'b0;
      err_trunc_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      last_q      <= last_d;
      tx_data_q   <= tx_data_d;
      tx_act_q    <= tx_act_d;
      err_trunc_q <= err_trunc_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    tx_act_d    = 1'b0;
    err_trunc_d = 1'b0;
    err_tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // uart_tx is never reset, so a frame left over from before reset must drain first.
        if (!i_tx_busy && arb_any) begin
          gidx_d  = arb_idx;
          count_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_req_valid[gidx_q]) begin
          tx_data_d = i_req_data[{gidx_q, 3'b000} +: 8];
          last_d    = i_req_last[gidx_q];
          if (count_q != '1) count_d = count_q + 1'b1;
          tx_act_d  = 1'b1;
          tmo_d     = '0;
          state_d   = StWaitHi;
        end
      end
      StWaitHi: begin
        if (i_tx_busy) begin
          state_d = StWaitLo;
        end else if (32'(tmo_q) + 32'd1 >= BUSY_TIMEOUT) begin
          err_tmo_d = 1'b1;
          ptr_d     = gidx_q;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitLo: begin
        if (!i_tx_busy) begin
          if (last_q) begin
            ptr_d   = gidx_q;
            state_d = StIdle;
          end else if (MAX_PKT_LEN != 0 && count_q == CntW'(MAX_PKT_LEN)) begin
            err_trunc_d = 1'b1;
            ptr_d       = gidx_q;
            state_d     = StIdle;
          end else begin
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_oh    = NUM_REQ'(1) << gidx_q;
    o_active    = (state_q != StIdle);
    o_grant     = o_active ? grant_oh : '0;
    o_req_ready = (state_q == StSend) ? (i_req_valid & grant_oh) : '0;
  end

  assign o_tx_data      = tx_data_q;
  assign o_tx_act       = tx_act_q;
  assign o_err_truncate = err_trunc_q;
  assign o_err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler against a behavioural uart_tx
// (10-bit frame at divider 4) that can be switched to a never-busy stub.
module tb_uart_tx_scheduler;

  localparam int NReq        = 4;
  localparam int FrameCycles = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_reset = 1'b1;
  logic [NReq-1:0]   i_req_valid = '0;
  logic [8*NReq-1:0] i_req_data = '0;
  logic [NReq-1:0]   i_req_last = '0;
  logic [NReq-1:0]   o_req_ready;
  logic [NReq-1:0]   o_grant;
  logic              o_active;
  logic [7:0]        o_tx_data;
  logic              o_tx_act;
  logic              i_tx_busy = 1'b0;
  logic              o_err_truncate;
  logic              o_err_timeout;

  uart_tx_scheduler #(
    .NUM_REQ      (NReq),
    .MAX_PKT_LEN  (3),
    .BUSY_TIMEOUT (4)
  ) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .i_req_last     (i_req_last),
    .o_req_ready    (o_req_ready),
    .o_grant        (o_grant),
    .o_active       (o_active),
    .o_tx_data      (o_tx_data),
    .o_tx_act       (o_tx_act),
    .i_tx_busy      (i_tx_busy),
    .o_err_truncate (o_err_truncate),
    .o_err_timeout  (o_err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester sources: per-requester ring of {last, data}.
  logic [8:0] src_mem [NReq][16];
  int         src_wr [NReq];
  int         src_rd [NReq];
  logic [NReq-1:0] rdy_s = '0;

  initial begin
    for (int k = 0; k < NReq; k++) begin
      src_wr[k] = 0;
      src_rd[k] = 0;
    end
  end

  always @(posedge clk) begin
    logic [8:0] entry;
    #1;
    for (int k = 0; k < NReq; k++) begin
      if (rdy_s[k] && src_rd[k] != src_wr[k]) src_rd[k] = src_rd[k] + 1;
      entry = src_mem[k][src_rd[k] % 16];
      i_req_valid[k]        = (src_rd[k] != src_wr[k]);
      i_req_data[8*k +: 8]  = entry[7:0];
      i_req_last[k]         = entry[8];
    end
  end

  // uart_tx model: no reset; stub mode never raises busy.
  logic       stub = 1'b0;
  int         frame_cnt = 0;
  logic [7:0] sent_mem [128];
  int         sent_n = 0;

  always @(posedge clk) begin
    if (!stub) begin
      if (!i_tx_busy && o_tx_act) begin
        i_tx_busy        <= 1'b1;
        frame_cnt        <= FrameCycles - 1;
        sent_mem[sent_n] <= o_tx_data;
        sent_n           <= sent_n + 1;
      end else if (i_tx_busy) begin
        if (frame_cnt == 0) i_tx_busy <= 1'b0;
        else frame_cnt <= frame_cnt - 1;
      end
    end
  end

  // Event monitor sampled on the falling edge.
  int         rdy_n = 0, rdy_cyc = 0;
  int         act_n = 0, act_cyc = 0;
  logic [7:0] act_data = '0;
  int         trunc_n = 0, tmo_n = 0, tmo_cyc = 0;
  logic [4:0] tmo_state = '0;
  logic       prev_busy = 1'b0;
  int         fall_cyc = 0;
  logic [3:0] fall_grant = '0;

  always @(negedge clk) begin
    rdy_s     <= o_req_ready;
    prev_busy <= i_tx_busy;
    if (o_req_ready != '0) begin
      rdy_n   <= rdy_n + 1;
      rdy_cyc <= cyc;
    end
    if (o_tx_act) begin
      act_n    <= act_n + 1;
      act_cyc  <= cyc;
      act_data <= o_tx_data;
    end
    if (o_err_truncate) trunc_n <= trunc_n + 1;
    if (o_err_timeout) begin
      tmo_n     <= tmo_n + 1;
      tmo_cyc   <= cyc;
      tmo_state <= {o_grant, o_active};
    end
    if (prev_busy && !i_tx_busy) begin
      fall_cyc   <= cyc;
      fall_grant <= o_grant;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_wr[k] % 16] = {l, d};
    src_wr[k] = src_wr[k] + 1;
  endtask

  function automatic logic srcs_empty();
    for (int k = 0; k < NReq; k++) if (src_rd[k] != src_wr[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_sent(input int n, input string name);
    int b = 0;
    while (sent_n < n && b < 2000) begin
      step();
      b++;
    end
    check(name, sent_n, n);
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while ((o_active || i_tx_busy || !srcs_empty()) && b < 2000) begin
      step();
      b++;
    end
    check(name, {o_active, i_tx_busy, srcs_empty()}, 3'b001);
  endtask

  typedef struct packed {
    logic [3:0]      mask;
    logic [2:0]      n;
    logic [3:0][1:0] order;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int base, b_act, b_rdy, b_tmo, b_trunc, b;
    logic [7:0] exp_bytes [7];

    // Expected service order assumes the pointer left by the preceding steps (3 at entry).
    vecs[0] = '{mask: 4'b1111, n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{mask: 4'b1010, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd1}};
    vecs[2] = '{mask: 4'b0101, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[3] = '{mask: 4'b1001, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[4] = '{mask: 4'b0110, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[5] = '{mask: 4'b0100, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[6] = '{mask: 4'b1100, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd3}};

    repeat (3) step();
    check("reset_outputs", {o_req_ready, o_grant, o_active, o_tx_act, o_err_truncate,
                            o_err_timeout, o_tx_data}, 0);
    i_reset = 1'b0;
    step();

    // Single byte from requester 0.
    base = sent_n; b_act = act_n; b_rdy = rdy_n;
    push(0, 8'h55, 1'b1);
    wait_sent(base + 1, "t1_sent");
    check("t1_ready_cycles", rdy_n - b_rdy, 1);
    check("t1_act_pulses", act_n - b_act, 1);
    check("t1_act_latency", act_cyc - rdy_cyc, 1);
    check("t1_act_data", act_data, 8'h55);
    check("t1_line_byte", sent_mem[base], 8'h55);
    wait_idle("t1_idle");
    check("t1_grant_at_busy_fall", fall_grant, 4'b0001);
    check("t1_grant_released", o_grant, 4'b0000);

    // Packet granularity: req1's whole packet before req3, then order for next contention.
    base = sent_n;
    push(1, 8'h1A, 1'b0); push(1, 8'h1B, 1'b1);
    push(3, 8'h3A, 1'b0); push(3, 8'h3B, 1'b1);
    wait_sent(base + 4, "t2_sent");
    exp_bytes[0] = 8'h1A; exp_bytes[1] = 8'h1B; exp_bytes[2] = 8'h3A; exp_bytes[3] = 8'h3B;
    for (int j = 0; j < 4; j++) check($sformatf("t2_pkt_byte%0d", j), sent_mem[base+j], exp_bytes[j]);
    wait_idle("t2_idle_a");
    base = sent_n;
    push(1, 8'h1C, 1'b1); push(3, 8'h3C, 1'b1);
    wait_sent(base + 2, "t2_sent_b");
    check("t2_again_first", sent_mem[base], 8'h1C);
    check("t2_again_second", sent_mem[base+1], 8'h3C);
    wait_idle("t2_idle_b");

    // Round-robin table of simultaneous single-byte packets.
    for (int v = 0; v < 7; v++) begin
      base = sent_n;
      for (int k = 0; k < NReq; k++)
        if (vecs[v].mask[k]) push(k, 8'((v + 1) * 16 + k), 1'b1);
      wait_sent(base + int'(vecs[v].n), $sformatf("vec%0d_sent", v));
      for (int j = 0; j < int'(vecs[v].n); j++)
        check($sformatf("vec%0d_byte%0d", v, j), sent_mem[base+j],
              8'((v + 1) * 16 + int'(vecs[v].order[j])));
      wait_idle($sformatf("vec%0d_idle", v));
    end

    // Truncation at 3 bytes; waiting req0 served before req2 resumes.
    base = sent_n; b_trunc = trunc_n;
    for (int i = 1; i <= 6; i++) push(2, 8'(8'hC0 + i), (i == 6));
    b = 0;
    while (o_grant != 4'b0100 && b < 300) begin step(); b++; end
    check("t3_req2_granted", o_grant, 4'b0100);
    push(0, 8'h0F, 1'b1);
    wait_sent(base + 7, "t3_sent");
    exp_bytes[0] = 8'hC1; exp_bytes[1] = 8'hC2; exp_bytes[2] = 8'hC3; exp_bytes[3] = 8'h0F;
    exp_bytes[4] = 8'hC4; exp_bytes[5] = 8'hC5; exp_bytes[6] = 8'hC6;
    for (int j = 0; j < 7; j++) check($sformatf("t3_byte%0d", j), sent_mem[base+j], exp_bytes[j]);
    wait_idle("t3_idle");
    check("t3_truncate_pulses", trunc_n - b_trunc, 1);

    // Busy never rises.
    stub = 1'b1; b_tmo = tmo_n; b_act = act_n;
    push(1, 8'h77, 1'b1);
    b = 0;
    while (tmo_n == b_tmo && b < 300) begin step(); b++; end
    repeat (4) step();
    check("t4_timeout_pulses", tmo_n - b_tmo, 1);
    check("t4_act_pulses", act_n - b_act, 1);
    check("t4_timeout_latency", tmo_cyc - act_cyc, 4);
    check("t4_grant_active_at_timeout", tmo_state, 5'b0);
    check("t4_idle_after", {o_grant, o_active}, 5'b0);
    stub = 1'b0;
    wait_idle("t4_idle");

    // Reset mid-frame; next grant waits for the frame to drain.
    base = sent_n;
    push(0, 8'hA5, 1'b1);
    wait_sent(base + 1, "t5_sent");
    repeat (5) step();
    check("t5_in_wait_lo", {o_active, i_tx_busy}, 2'b11);
    i_reset = 1'b1;
    push(1, 8'h5A, 1'b1);
    step();
    check("t5_outputs_cleared", {o_req_ready, o_grant, o_active, o_tx_act, o_err_truncate,
                                 o_err_timeout, o_tx_data}, 0);
    check("t5_uart_still_busy", i_tx_busy, 1'b1);
    i_reset = 1'b0;
    b_act = act_n;
    b = 0;
    while (act_n == b_act && b < 300) begin step(); b++; end
    check("t5_act_seen", act_n - b_act, 1);
    check("t5_act_after_drain", act_cyc - fall_cyc, 2);
    check("t5_act_data", act_data, 8'h5A);
    wait_idle("t5_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
